hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard sequencer for the 5-stage MIPS core; sits beside the forwarding unit in the ID stage.
//  Detects hazards forwarding cannot cover (load-use, jr/jalr on a load result) and inserts timed stall bubbles.
//  Issues flushes for ID jumps and EX-taken branches, and freezes the whole pipe while data memory is not ready.
// PARAMETERS
//  LOAD_USE_STALL  1   bubbles for an EX-stage load feeding the ID instruction (Rs/Rt)
//  JR_LOAD_STALL   2   bubbles for jr/jalr whose Rs is written by the EX-stage load
//  CNT_W           2   stall-counter width; must hold max(LOAD_USE_STALL, JR_LOAD_STALL)
// PORTS
//  clk                 in   1  core clock, rising edge
//  reset               in   1  synchronous, active-high
//  IFID_Rs, IFID_Rt    in   5  source registers of the ID instruction
//  ID_UsesRs, ID_UsesRt in  1  ID instruction actually reads Rs / Rt
//  ID_PCSrc            in   3  ID PC select: 000 seq, 001 j/jal, 010 jr/jalr
//  IDEX_MemRead        in   1  EX-stage instruction is a load
//  IDEX_RegWrite       in   1  EX-stage register write enable
//  IDEX_RegWriteAddr   in   5  EX-stage destination register
//  EXMEM_MemRead       in   1  MEM-stage instruction is a load
//  EXMEM_RegWriteAddr  in   5  MEM-stage destination register
//  EX_BranchTaken      in   1  branch resolved taken in EX this cycle
//  MEM_Stall           in   1  data memory not ready; freeze request
//  PC_Write            out  1  PC update enable
//  IFID_Write          out  1  IF/ID register load enable
//  IFID_Flush          out  1  IF/ID register cleared to nop next edge
//  IDEX_Flush          out  1  ID/EX register loaded with bubble next edge
//  Pipe_Hold           out  1  hold ID/EX, EX/MEM, MEM/WB (memory freeze)
//  Stalled             out  1  a hazard stall is active this cycle
// BEHAVIOUR
//  States: RUN, STALL. stall_cnt[CNT_W-1:0] counts remaining bubbles after the current one.
//  LU hazard (RUN): IDEX_MemRead & IDEX_RegWrite & IDEX_RegWriteAddr!=0 & ((ID_UsesRs & Rs match) | (ID_UsesRt & Rt match)).
//  JR hazard (RUN), ID_PCSrc==010, producer != $0:
//   IDEX load writing IFID_Rs -> JR_LOAD_STALL bubbles; EXMEM load writing IFID_Rs -> 1 bubble; non-load -> none (forwarded).
//  Bubble cycle: PC_Write=0, IFID_Write=0, IDEX_Flush=1, Stalled=1, IFID_Flush=0.
//  RUN + hazard of N bubbles: bubble now; N>1 -> STALL with stall_cnt=N-2; N==1 stay RUN.
//  STALL: bubble every cycle; stall_cnt==0 -> RUN, else decrement. Hazard inputs ignored in STALL.
//  No hazard in RUN: PC_Write=1, IFID_Write=1, IDEX_Flush=0; ID_PCSrc!=000 -> IFID_Flush=1 (kill delay slot fetch).
//  EX_BranchTaken (any state, not frozen): IFID_Flush=1, IDEX_Flush=1, PC_Write=1, IFID_Write=1, Stalled=0; next state RUN, cnt 0.
//  MEM_Stall: highest priority after reset; Pipe_Hold=1, PC_Write=0, IFID_Write=0, no flushes; state/cnt frozen.
//  Priority: reset > MEM_Stall > EX_BranchTaken > hazard/STALL > ID jump flush > normal.
//  Hazard check only in RUN, so a jr released from STALL is not re-stalled (producer now in MEM/WB, forwarded).
//  Reset (sync, any state incl. mid-stall): next state RUN, cnt 0; while reset high outputs forced to
//   PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, Pipe_Hold=0, Stalled=0.
//  Outputs combinational from state + inputs; no extra latency beyond the state register.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs Stall_Count[31:0], Flush_Count[31:0], Freeze_Count[31:0];
//   each increments by 1 per cycle with Stalled / (IFID_Flush|IDEX_Flush) / Pipe_Hold; reset to 0; wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared header pipeline_defs.vh: PCSrc encodings (PCSRC_SEQ/JUMP/JR), state codes RUN/STALL, NOP word.
//  One sub-module: hazard_detect (combinational register-compare; returns hazard flag + bubble count N).
//  Top holds FSM, stall_cnt, priority mux and optional stats counters.
// TESTING
//  lw $8 in EX, add reading $8 in ID -> 1 cycle PC_Write=0,IDEX_Flush=1; then normal, Stalled=0.
//  lw $9 in EX, jr $9 in ID -> 2 consecutive bubble cycles (STALL cnt 0), 3rd cycle PC_Write=1,IFID_Flush=1.
//  addi $9 in EX, jr $9 -> no stall, IFID_Flush=1 same cycle; lw writing $0 + reader of $0 -> no stall.
//  During JR STALL cycle 1 raise EX_BranchTaken -> both flushes=1, Stalled=0, next cycle RUN.
//  MEM_Stall high 3 cycles mid-STALL -> Pipe_Hold=1 x3, cnt unchanged, bubble resumes after release.
//  reset pulsed in STALL -> forced reset outputs, then RUN; HAZARD_STATS_EN: counters read 0 after reset.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared definitions for the ID-stage hazard sequencer of the 5-stage MIPS
//   core: PC-select encodings, sequencer states and the NOP instruction word.
// -----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

   // ID-stage PC select encodings
   localparam logic [2:0] PCSRC_SEQ  = 3'b000;
   localparam logic [2:0] PCSRC_JUMP = 3'b001;
   localparam logic [2:0] PCSRC_JR   = 3'b010;

   // Instruction word loaded into flushed pipeline registers
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_hazard_detect
//   Combinational register compare for hazards forwarding cannot resolve.
//   Ports:
//     IFID_Rs/Rt, ID_UsesRs/Rt   source operands of the ID instruction
//     ID_PCSrc                   ID PC select (jr/jalr detection)
//     IDEX_*                     EX-stage load / write-back destination
//     EXMEM_*                    MEM-stage load destination
//     hazard                     a stall is required
//     bubbles                    number of bubble cycles required (N)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl_hazard_detect
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_USE_STALL = 1,
   parameter int unsigned JR_LOAD_STALL  = 2,
   parameter int unsigned CNT_W          = 2
) (
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic [2:0]       ID_PCSrc,
   input  logic             IDEX_MemRead,
   input  logic             IDEX_RegWrite,
   input  logic [4:0]       IDEX_RegWriteAddr,
   input  logic             EXMEM_MemRead,
   input  logic [4:0]       EXMEM_RegWriteAddr,
   output logic             hazard,
   output logic [CNT_W-1:0] bubbles
);

   logic idex_load;
   logic is_jr;
   logic load_use;
   logic jr_idex_load;
   logic jr_exmem_load;

   assign idex_load     = IDEX_MemRead & IDEX_RegWrite & (IDEX_RegWriteAddr != 5'd0);
   assign is_jr         = (ID_PCSrc == PCSRC_JR);
   assign load_use      = idex_load & ((ID_UsesRs & (IFID_Rs == IDEX_RegWriteAddr)) |
                                       (ID_UsesRt & (IFID_Rt == IDEX_RegWriteAddr)));
   assign jr_idex_load  = is_jr & idex_load & (IFID_Rs == IDEX_RegWriteAddr);
   assign jr_exmem_load = is_jr & EXMEM_MemRead & (EXMEM_RegWriteAddr != 5'd0) &
                          (IFID_Rs == EXMEM_RegWriteAddr);

   // A jr on an EX-stage load dominates the plain load-use count
   always_comb begin
      hazard  = 1'b1;
      bubbles = '0;
      if (jr_idex_load)
         bubbles = CNT_W'(JR_LOAD_STALL);
      else if (load_use)
         bubbles = CNT_W'(LOAD_USE_STALL);
      else if (jr_exmem_load)
         bubbles = CNT_W'(1);
      else
         hazard = 1'b0;
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   ID-stage pipeline hazard sequencer: inserts load-use / jr-on-load bubbles,
//   flushes for ID jumps and EX-taken branches, freezes on data-memory stall.
//   Inputs : clk, reset (sync, active-high), IFID_Rs/Rt, ID_UsesRs/Rt,
//            ID_PCSrc, IDEX_MemRead/RegWrite/RegWriteAddr,
//            EXMEM_MemRead/RegWriteAddr, EX_BranchTaken, MEM_Stall
//   Outputs: PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold, Stalled
//   Optional (macro HAZARD_STATS_EN): Stall_Count, Flush_Count, Freeze_Count
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_USE_STALL = 1,
   parameter int unsigned JR_LOAD_STALL  = 2,
   parameter int unsigned CNT_W          = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  IFID_Rs,
   input  logic [4:0]  IFID_Rt,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic [2:0]  ID_PCSrc,
   input  logic        IDEX_MemRead,
   input  logic        IDEX_RegWrite,
   input  logic [4:0]  IDEX_RegWriteAddr,
   input  logic        EXMEM_MemRead,
   input  logic [4:0]  EXMEM_RegWriteAddr,
   input  logic        EX_BranchTaken,
   input  logic        MEM_Stall,
   output logic        PC_Write,
   output logic        IFID_Write,
   output logic        IFID_Flush,
   output logic        IDEX_Flush,
   output logic        Pipe_Hold,
   output logic        Stalled
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] Stall_Count,
   output logic [31:0] Flush_Count,
   output logic [31:0] Freeze_Count
`endif
);

   state_t           state;
   logic [CNT_W-1:0] stall_cnt;
   logic             hazard;
   logic [CNT_W-1:0] bubbles;
   logic             bubble_now;

   hazard_stall_ctrl_hazard_detect #(
      .LOAD_USE_STALL (LOAD_USE_STALL),
      .JR_LOAD_STALL  (JR_LOAD_STALL),
      .CNT_W          (CNT_W)
   ) u_detect (
      .IFID_Rs            (IFID_Rs),
      .IFID_Rt            (IFID_Rt),
      .ID_UsesRs          (ID_UsesRs),
      .ID_UsesRt          (ID_UsesRt),
      .ID_PCSrc           (ID_PCSrc),
      .IDEX_MemRead       (IDEX_MemRead),
      .IDEX_RegWrite      (IDEX_RegWrite),
      .IDEX_RegWriteAddr  (IDEX_RegWriteAddr),
      .EXMEM_MemRead      (EXMEM_MemRead),
      .EXMEM_RegWriteAddr (EXMEM_RegWriteAddr),
      .hazard             (hazard),
      .bubbles            (bubbles)
   );

   // Hazards are only evaluated in RUN: a jr released from STALL now has its
   // producer in MEM/WB where forwarding covers it.
   assign bubble_now = (state == ST_STALL) | hazard;

   always_comb begin
      PC_Write   = 1'b1;
      IFID_Write = 1'b1;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      Pipe_Hold  = 1'b0;
      Stalled    = 1'b0;
      if (reset) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
      end else if (MEM_Stall) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         Pipe_Hold  = 1'b1;
      end else if (EX_BranchTaken) begin
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
      end else if (bubble_now) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         IDEX_Flush = 1'b1;
         Stalled    = 1'b1;
      end else if (ID_PCSrc != PCSRC_SEQ) begin
         IFID_Flush = 1'b1;
      end
   end

   // stall_cnt holds bubbles remaining after the current one
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         stall_cnt <= '0;
      end else if (MEM_Stall) begin
         state     <= state;
         stall_cnt <= stall_cnt;
      end else if (EX_BranchTaken) begin
         state     <= ST_RUN;
         stall_cnt <= '0;
      end else if (state == ST_STALL) begin
         if (stall_cnt == '0)
            state <= ST_RUN;
         else
            stall_cnt <= stall_cnt - CNT_W'(1);
      end else if (hazard && (bubbles > CNT_W'(1))) begin
         state     <= ST_STALL;
         stall_cnt <= bubbles - CNT_W'(2);
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         Stall_Count  <= '0;
         Flush_Count  <= '0;
         Freeze_Count <= '0;
      end else begin
         if (Stalled)                 Stall_Count  <= Stall_Count + 32'd1;
         if (IFID_Flush | IDEX_Flush) Flush_Count  <= Flush_Count + 32'd1;
         if (Pipe_Hold)               Freeze_Count <= Freeze_Count + 32'd1;
      end
   end
`endif

endmodule
